// File: rtl/seg7_pkg.sv
// Shared segment glyphs and slot-state encoding for the seven-segment scan driver.
// Patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry n is the glyph for hex digit n (index 15 listed first).
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {
    ACTIVE = 1'b0,
    BLANK  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment lookup; zero latency.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_LUT[i_nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode display scanner with per-slot blanking and frame-synchronous double buffering.
// Outputs are registered one cycle behind the slot counter; a load never stalls, the last load before a frame boundary wins.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_data_in,
  input  logic [NUM_DIGITS-1:0]   i_dp_in,
  input  logic [NUM_DIGITS-1:0]   i_digit_en,
  input  logic                    i_lz_suppress,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_frame_done,
  output logic                    o_pending
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] LAST_CNT    = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] PRE_LAST    = CW'(REFRESH_DIV - 2);
  localparam logic [CW-1:0] BLANK_START = CW'(REFRESH_DIV - BLANK_CYCLES);
  localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  slot_state_e             r_state;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic [4*NUM_DIGITS-1:0] r_buf;
  logic [NUM_DIGITS-1:0]   r_buf_dp;

  logic                    w_wrap;
  logic [CW-1:0]           w_cnt_nxt;
  logic [4*NUM_DIGITS-1:0] w_upper;
  logic [3:0]              w_nib;
  logic                    w_lz_blank;
  logic [6:0]              w_dec;
  logic [NUM_DIGITS-1:0]   w_an_sel;

  assign w_wrap    = (r_cnt == LAST_CNT);
  assign w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;
  assign w_upper   = r_shadow >> {r_idx, 2'b00};
  assign w_nib     = w_upper[3:0];
  // Upper-aligned remainder is zero exactly when this digit and all above it are zero.
  assign w_lz_blank = i_lz_suppress && (r_idx != '0) && (w_upper == '0);
  assign w_an_sel   = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx);

  hex_to_seg7 u_dec (
    .i_nibble (w_nib),
    .o_seg    (w_dec)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_state      <= ACTIVE;
      r_shadow     <= '0;
      r_shadow_dp  <= '0;
      r_buf        <= '0;
      r_buf_dp     <= '0;
      o_pending    <= 1'b0;
      o_frame_done <= 1'b0;
      o_an         <= '1;
      o_seg        <= SEG_BLANK;
      o_dp         <= 1'b1;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_wrap) begin
        r_idx   <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        r_state <= ACTIVE;
      end else if ((BLANK_CYCLES > 0) && (w_cnt_nxt == BLANK_START)) begin
        r_state <= BLANK;
      end

      // Raised one cycle early so the pulse lands on the final cycle of the frame.
      o_frame_done <= (r_idx == LAST_IDX) && (r_cnt == PRE_LAST);

      if (o_frame_done) begin
        if (i_load) begin
          r_shadow    <= i_data_in;
          r_shadow_dp <= i_dp_in;
        end else if (o_pending) begin
          r_shadow    <= r_buf;
          r_shadow_dp <= r_buf_dp;
        end
        o_pending <= 1'b0;
      end else if (i_load) begin
        r_buf     <= i_data_in;
        r_buf_dp  <= i_dp_in;
        o_pending <= 1'b1;
      end

      if ((r_state == ACTIVE) && i_digit_en[r_idx]) begin
        o_an  <= w_an_sel;
        o_seg <= w_lz_blank ? SEG_BLANK : w_dec;
        o_dp  <= ~r_shadow_dp[r_idx];
      end else begin
        o_an  <= '1;
        o_seg <= SEG_BLANK;
        o_dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed plus random bench for seg7_scan_driver against a cycle-position reference model.
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FP = N * RD;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [4*N-1:0] data_in;
  logic [N-1:0]  dp_in;
  logic [N-1:0]  digit_en;
  logic          lz;
  logic [N-1:0]  an;
  logic [6:0]    seg;
  logic          dp;
  logic          frame_done;
  logic          pending;

  int checks = 0;
  int errors = 0;

  // Reference model state: mt is the cycle position since the last reset.
  int             mt;
  logic [4*N-1:0] msh, mbuf;
  logic [N-1:0]   msdp, mbdp;
  logic           mpend;
  logic [N-1:0]   ean;
  logic [6:0]     eseg;
  logic           edp, efd;

  seg7_scan_driver #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_load        (load),
    .i_data_in     (data_in),
    .i_dp_in       (dp_in),
    .i_digit_en    (digit_en),
    .i_lz_suppress (lz),
    .o_an          (an),
    .o_seg         (seg),
    .o_dp          (dp),
    .o_frame_done  (frame_done),
    .o_pending     (pending)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  pos, idx, off;
    bit  allz;
    if (rst) begin
      mt = 0; msh = '0; msdp = '0; mbuf = '0; mbdp = '0; mpend = 1'b0;
      ean = '1; eseg = 7'h7F; edp = 1'b1; efd = 1'b0;
    end else begin
      pos = mt % FP;
      idx = pos / RD;
      off = pos % RD;
      if (off < RD - BC && digit_en[idx]) begin
        allz = 1'b1;
        for (int j = idx; j < N; j++)
          if (msh[4*j +: 4] != 4'h0) allz = 1'b0;
        ean  = ~(4'(1) << idx);
        eseg = (lz && idx > 0 && allz) ? 7'h7F : GLYPH[msh[4*idx +: 4]];
        edp  = ~msdp[idx];
      end else begin
        ean = '1; eseg = 7'h7F; edp = 1'b1;
      end
      if (pos == FP - 1) begin
        if (load) begin
          msh = data_in; msdp = dp_in;
        end else if (mpend) begin
          msh = mbuf; msdp = mbdp;
        end
        mpend = 1'b0;
      end else if (load) begin
        mbuf = data_in; mbdp = dp_in; mpend = 1'b1;
      end
      mt++;
      efd = ((mt % FP) == FP - 1);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("an", 32'(an), 32'(ean));
    chk("seg", 32'(seg), 32'(eseg));
    chk("dp", 32'(dp), 32'(edp));
    chk("frame_done", 32'(frame_done), 32'(efd));
    chk("pending", 32'(pending), 32'(mpend));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_once(input logic [15:0] d, input logic [3:0] p);
    load = 1'b1; data_in = d; dp_in = p;
    step();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; data_in = '0; dp_in = '0; digit_en = 4'hF; lz = 1'b0;
    // Reset and idle display of a cleared shadow.
    run(3);
    rst = 1'b0;
    run(40);

    // Basic load; pending held until the frame boundary.
    while (mt % FP != 5) step();
    load_once(16'h1234, 4'b0101);
    run(70);

    // Leading-zero suppression.
    lz = 1'b1;
    load_once(16'h0050, 4'b0000);
    run(70);
    load_once(16'h0000, 4'b0010);
    run(70);
    lz = 1'b0;

    // Disabled digit keeps its anode off without changing frame period.
    digit_en = 4'b1101;
    load_once(16'h9E7C, 4'b1010);
    run(70);
    digit_en = 4'hF;

    // Load coinciding with the frame boundary commits directly.
    while (mt % FP != FP - 1) step();
    load_once(16'h8888, 4'b1111);
    run(40);

    // Reset mid-frame discards uncommitted data.
    load_once(16'hABCD, 4'b0011);
    while (mt % FP != 13) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(40);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      load    = ($urandom_range(0, 5) == 0);
      data_in = 16'($urandom) >> (4 * $urandom_range(0, 4));
      dp_in   = 4'($urandom);
      if ($urandom_range(0, 40) == 0) digit_en = 4'($urandom);
      if ($urandom_range(0, 40) == 0) lz = 1'($urandom);
      rst = ($urandom_range(0, 250) == 0);
      step();
    end
    rst = 1'b0; load = 1'b0;
    run(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Multiplexed seven-segment display driver for the board's N-digit, common-anode display.
- Divides the system clock into per-digit refresh slots and walks a digit index that selects one anode at a time.
- Decodes the selected hex nibble to segment patterns, inserting a blanking gap between digits to stop ghosting.
- Double-buffers display data so the value shown changes only at a frame boundary, which prevents tearing.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; must be 2..8.
- REFRESH_DIV, 100000: clock cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 1000: cycles at the end of each slot with all anodes off; must be < REFRESH_DIV.

Ports:
- clock  in  1  system clock; every register is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  single-cycle strobe; captures data_in and dp_in into the pending buffer.
- data_in  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i, and digit 0 is rightmost.
- dp_in  in  NUM_DIGITS  decimal-point request per digit; 1 = lit.
- digit_en  in  NUM_DIGITS  per-digit enable, sampled live; 0 keeps that anode off during its slot.
- lz_suppress  in  1  1 = blank leading zero digits; sampled live.
- an  out  NUM_DIGITS  anodes, active-low, registered.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low, registered.
- dp  out  1  decimal-point cathode, active-low, registered.
- frame_done  out  1  one-cycle pulse on the last cycle of digit NUM_DIGITS-1's slot.
- pending  out  1  high while loaded data waits for a frame boundary.

Behaviour:
- Reset values: an = all 1s, seg = 7'h7F, dp = 1, frame_done = 0, pending = 0.
- Reset also clears: slot counter = 0, digit index = 0, shadow data and shadow dp = 0, pending buffer = 0, state = ACTIVE.
- Slot counter counts 0..REFRESH_DIV-1 and wraps. On wrap, the digit index increments, wrapping from NUM_DIGITS-1 to 0.
- State machine (two states):
  - ACTIVE: slot counter < REFRESH_DIV-BLANK_CYCLES.
  - BLANK: all remaining cycles of the slot.
  - Transitions: ACTIVE->BLANK when the counter reaches REFRESH_DIV-BLANK_CYCLES; BLANK->ACTIVE on counter wrap.
- Outputs are registered: one cycle of latency from internal state to an/seg/dp.
- ACTIVE with digit_en[idx] = 1: an = one-hot-low at idx; seg = decode(shadow nibble idx); dp = ~shadow_dp[idx].
- ACTIVE with digit_en[idx] = 0, or any BLANK cycle: an = all 1s, seg = 7'h7F, dp = 1.
- Decode covers 0-F:
  - 0 = 7'b1000000, 4 = 7'b0011001, 5 = 7'b0010010, 8 = 7'b0000000.
  - A/b/C/d/E/F use conventional hex glyphs.
- Leading-zero suppression: with lz_suppress = 1, digit i > 0 is suppressed when shadow nibbles NUM_DIGITS-1 down to i are all zero.
  - A suppressed digit shows seg = 7'h7F; its anode still follows the normal slot rules, and dp still follows shadow_dp.
  - Digit 0 is never suppressed.
- load = 1: pending buffer <= {data_in, dp_in}; pending <= 1. A later load before the boundary overwrites the buffer; last load wins.
- Frame boundary is the cycle where frame_done = 1:
  - If pending = 1: shadow <= pending buffer; pending <= 0.
  - If load = 1 in the same cycle: shadow <= data_in/dp_in directly and pending stays 0.
- reset asserted mid-slot or mid-frame takes effect at the next edge; loaded but uncommitted data is discarded.
- Frame period = NUM_DIGITS*REFRESH_DIV cycles, whatever digit_en is set to. Brightness therefore stays constant.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry active-low segment pattern constant,
  - SEG_BLANK = 7'h7F,
  - the slot state encoding (ACTIVE, BLANK).
- One sub-module, hex_to_seg7: 4-bit nibble in, 7-bit active-low segments out, combinational lookup from the package constant.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, digit_en=4'hF, lz_suppress=0 unless stated):
1. Reset 3 cycles, then idle -> an = 1111 the first cycle after release. Digit 0 then shows seg = 7'b1000000. frame_done pulses every 32 cycles.
2. Load 16'h1234 at cycle 5 -> pending = 1 until the first frame_done, then 0. The next frame shows digit 0 = 4 (7'b0011001). Each slot is an = 1110 for 6 cycles then 1111 for 2, and the digit sequence is 1110, 1101, 1011, 0111.
3. Load 16'h0050, lz_suppress = 1 -> digits 3 and 2 show seg = 7'h7F, digit 1 shows 5 (7'b0010010), digit 0 shows 0. Load 16'h0000 -> only digit 0 lit, showing 0.
4. digit_en = 4'b1101 -> an stays 1111 for the whole slot of digit 1. The frame period is still 32 cycles.
5. load with data 16'h8888 on the frame_done cycle -> pending stays 0. The next frame shows 8 (7'b0000000) on all digits.
6. Load 16'hABCD, then reset at cycle 13 of the frame -> next cycle an = 1111 and pending = 0. After release, digit 0 shows 0, because shadow was cleared.
